// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
//   Shares one sprite draw engine between NUM_REQ game-object requesters using
//   round-robin arbitration. The winner's x/y/sprite id are latched for the
//   engine, a one-cycle start is issued, and the block waits for eng_done. A
//   watchdog aborts a draw that never completes and sets a sticky err flag.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   req               per-requester draw request (level, held until granted)
//   req_x, req_y      packed 10-bit positions, requester i at [10i+9:10i]
//   req_sid           packed SID_W-bit sprite ids
//   grant             one-hot, one-cycle pulse when a requester wins
//   served            one-hot, one-cycle pulse when that draw completes/aborts
//   eng_start         one-cycle start pulse to the draw engine
//   eng_x/eng_y/eng_sid  latched draw parameters for the engine
//   eng_done          engine finished (level or pulse)
//   eng_abort         one-cycle pulse on watchdog expiry
//   busy              high whenever not IDLE
//   err, err_clr      sticky timeout flag and its clear
module sprite_draw_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SID_W   = 3,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [10*NUM_REQ-1:0]      req_x,
  input  logic [10*NUM_REQ-1:0]      req_y,
  input  logic [SID_W*NUM_REQ-1:0]   req_sid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         served,
  output logic                       eng_start,
  output logic [9:0]                 eng_x,
  output logic [9:0]                 eng_y,
  output logic [SID_W-1:0]           eng_sid,
  input  logic                       eng_done,
  output logic                       eng_abort,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic               start_q, start_d;
  logic               abort_q, abort_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [9:0]         ex_q, ex_d;
  logic [9:0]         ey_q, ey_d;
  logic [SID_W-1:0]   esid_q, esid_d;

  logic               hi_found, lo_found;
  logic [IDX_W-1:0]   hi_idx, lo_idx, pick_idx;
  logic               timeout;

  // Round-robin pick: lowest set index at or above the pointer wins; if none,
  // the lowest set index below the pointer (the wrapped search).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (IDX_W'(i) >= rr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  // Pulsed outputs are computed on the transition into the state they belong
  // to, so the registered copies line up with the state itself.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    wd_d     = wd_q;
    grant_d  = '0;
    served_d = '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    ex_d     = ex_q;
    ey_d     = ey_q;
    esid_d   = esid_q;
    timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d           = S_ISSUE;
          win_d             = pick_idx;
          ex_d              = req_x[10*pick_idx +: 10];
          ey_d              = req_y[10*pick_idx +: 10];
          esid_d            = req_sid[SID_W*pick_idx +: SID_W];
          grant_d[pick_idx] = 1'b1;
          start_d           = 1'b1;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (eng_done) begin
          state_d         = S_RELEASE;
          served_d[win_q] = 1'b1;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          state_d         = S_RELEASE;
          served_d[win_q] = 1'b1;
          abort_d         = 1'b1;
          timeout         = 1'b1;
        end
      end
      S_RELEASE: begin
        rr_d    = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      served_q <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ex_q     <= '0;
      ey_q     <= '0;
      esid_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      served_q <= served_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ex_q     <= ex_d;
      ey_q     <= ey_d;
      esid_q   <= esid_d;
    end
  end

  assign grant     = grant_q;
  assign served    = served_q;
  assign eng_start = start_q;
  assign eng_abort = abort_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign eng_x     = ex_q;
  assign eng_y     = ey_q;
  assign eng_sid   = esid_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler
//   Directed bench for sprite_draw_scheduler: reset state, single draw with
//   latched parameters, round-robin order, eng_done ignored in ISSUE, watchdog
//   abort and err handling, done/timeout tie, and reset during a draw.
module tb_sprite_draw_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SID_W   = 3;
  localparam int unsigned TIMEOUT = 4096;
  localparam int unsigned TO_W    = 13;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [10*NUM_REQ-1:0]    req_x;
  logic [10*NUM_REQ-1:0]    req_y;
  logic [SID_W*NUM_REQ-1:0] req_sid;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       served;
  logic                     eng_start;
  logic [9:0]               eng_x;
  logic [9:0]               eng_y;
  logic [SID_W-1:0]         eng_sid;
  logic                     eng_done;
  logic                     eng_abort;
  logic                     busy;
  logic                     err;
  logic                     err_clr;

  int total;
  int bad;

  sprite_draw_scheduler #(
    .NUM_REQ (NUM_REQ),
    .SID_W   (SID_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sid   (req_sid),
    .grant     (grant),
    .served    (served),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_sid   (eng_sid),
    .eng_done  (eng_done),
    .eng_abort (eng_abort),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [9:0] x, input logic [9:0] y,
                            input logic [SID_W-1:0] sid);
    req_x[10*i +: 10]        = x;
    req_y[10*i +: 10]        = y;
    req_sid[SID_W*i +: SID_W] = sid;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    err_clr  = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, checks it, completes the draw with eng_done
  // and checks the served pulse. Returns with the DUT in RELEASE.
  task automatic do_draw(input logic [NUM_REQ-1:0] exp, input string name);
    int n;
    n = 0;
    tick;
    while (grant == '0 && n < 10) begin
      tick;
      n++;
    end
    total++;
    if (grant !== exp) begin
      bad++;
      $display("FAIL %s grant: got %b expected %b", name, grant, exp);
    end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    total++;
    if (served !== exp) begin
      bad++;
      $display("FAIL %s served: got %b expected %b", name, served, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req     = 4'b1111;
    tick;
    tick;
    total++;
    if ({grant, served, eng_start, eng_abort, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_ctl: got %b expected 0",
               {grant, served, eng_start, eng_abort, busy, err});
    end
    total++;
    if ({eng_x, eng_y, eng_sid} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h expected 0", {eng_x, eng_y, eng_sid});
    end
    req     = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    set_fields(2, 10'd100, 10'd50, 3'd2);
    req = 4'b0100;
    tick;
    total++;
    if (grant !== 4'b0100 || eng_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got grant=%b start=%b busy=%b expected 0100 1 1",
               grant, eng_start, busy);
    end
    total++;
    if (eng_x !== 10'd100 || eng_y !== 10'd50 || eng_sid !== 3'd2) begin
      bad++;
      $display("FAIL single_latch: got x=%0d y=%0d sid=%0d expected 100 50 2",
               eng_x, eng_y, eng_sid);
    end
    req = '0;
    set_fields(2, 10'd333, 10'd444, 3'd5);
    tick;
    total++;
    if (grant !== '0 || eng_start !== 1'b0 || eng_x !== 10'd100 || eng_y !== 10'd50) begin
      bad++;
      $display("FAIL single_hold: got grant=%b start=%b x=%0d y=%0d expected 0000 0 100 50",
               grant, eng_start, eng_x, eng_y);
    end
    repeat (19) tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    total++;
    if (served !== 4'b0100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_served: got served=%b busy=%b expected 0100 1", served, busy);
    end
    tick;
    total++;
    if (served !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got served=%b busy=%b expected 0000 0", served, busy);
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    req = 4'b1010;
    do_draw(4'b0010, "rr_a1");
    do_draw(4'b1000, "rr_a3");
    req = 4'b1111;
    do_draw(4'b0001, "rr_b0");
    do_draw(4'b0010, "rr_b1");
    do_draw(4'b0100, "rr_b2");
    do_draw(4'b1000, "rr_b3");
    do_draw(4'b0001, "rr_b0again");
    req = '0;
    tick;
  endtask

  task automatic test_done_in_issue;
    logic early;
    do_reset;
    req = 4'b0001;
    tick;
    eng_done = 1'b1;
    req      = '0;
    tick;
    eng_done = 1'b0;
    early    = 1'b0;
    repeat (3) begin
      if (served !== '0 || busy !== 1'b1) early = 1'b1;
      tick;
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL issue_done_ignored: got early_release=%b expected 0", early);
    end
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    total++;
    if (served !== 4'b0001) begin
      bad++;
      $display("FAIL issue_later_done: got served=%b expected 0001", served);
    end
    tick;
  endtask

  task automatic test_watchdog;
    logic early;
    do_reset;
    req = 4'b0001;
    tick;
    req = '0;
    tick;
    early = 1'b0;
    for (int unsigned i = 1; i < TIMEOUT; i++) begin
      tick;
      if (eng_abort !== 1'b0 || served !== '0) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL wd_early: got early_abort=%b expected 0", early);
    end
    err_clr = 1'b1;
    tick;
    total++;
    if (eng_abort !== 1'b1 || err !== 1'b1 || served !== 4'b0001) begin
      bad++;
      $display("FAIL wd_abort: got abort=%b err=%b served=%b expected 1 1 0001",
               eng_abort, err, served);
    end
    tick;
    err_clr = 1'b0;
    total++;
    if (eng_abort !== 1'b0 || err !== 1'b0 || served !== '0) begin
      bad++;
      $display("FAIL wd_clear: got abort=%b err=%b served=%b expected 0 0 0000",
               eng_abort, err, served);
    end
  endtask

  task automatic test_done_vs_timeout;
    do_reset;
    req = 4'b0010;
    tick;
    req = '0;
    tick;
    repeat (TIMEOUT - 1) tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    total++;
    if (eng_abort !== 1'b0 || err !== 1'b0 || served !== 4'b0010) begin
      bad++;
      $display("FAIL tie_done_wins: got abort=%b err=%b served=%b expected 0 0 0010",
               eng_abort, err, served);
    end
    tick;
    total++;
    if (eng_abort !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tie_after: got abort=%b err=%b busy=%b expected 0 0 0",
               eng_abort, err, busy);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_fields(0, 10'd7, 10'd9, 3'd1);
    set_fields(3, 10'd600, 10'd400, 3'd6);
    req = 4'b0100;
    do_draw(4'b0100, "mid_pre");
    req = 4'b1000;
    tick;
    tick;
    req = '0;
    repeat (6) tick;
    reset_n = 1'b0;
    req     = 4'b1001;
    tick;
    total++;
    if ({grant, served, eng_start, eng_abort, busy, err} !== '0 ||
        {eng_x, eng_y, eng_sid} !== '0) begin
      bad++;
      $display("FAIL mid_reset_clear: got ctl=%b data=%h expected 0 0",
               {grant, served, eng_start, eng_abort, busy, err}, {eng_x, eng_y, eng_sid});
    end
    tick;
    total++;
    if (served !== '0 || eng_abort !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_served: got served=%b abort=%b expected 0000 0", served, eng_abort);
    end
    reset_n = 1'b1;
    tick;
    total++;
    if (grant !== 4'b0001 || eng_x !== 10'd7 || eng_sid !== 3'd1) begin
      bad++;
      $display("FAIL mid_ptr_zero: got grant=%b x=%0d sid=%0d expected 0001 7 1",
               grant, eng_x, eng_sid);
    end
    req = '0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    req      = '0;
    req_x    = '0;
    req_y    = '0;
    req_sid  = '0;
    eng_done = 1'b0;
    err_clr  = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_done_in_issue;
    test_watchdog;
    test_done_vs_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
